fu_issue_ctrl: RTL and testbench
================================

FU_ISSUE_CTRL -- requirements
Module: fu_issue_ctrl

Interface
REQ-001 SHALL have parameter NUM_FU, default 4, number of attached EN/finish functional-unit slots.
REQ-002 SHALL have parameter DATA_W, default 32, result width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port issue_valid  input  1  pipeline offers an operation.
REQ-006 SHALL have port issue_fu  input  log2(NUM_FU)  target slot index.
REQ-007 SHALL have port issue_rd  input  5  destination register.
REQ-008 SHALL have port issue_ready  output  1  operation accepted when issue_valid and issue_ready are both high at a rising edge.
REQ-009 SHALL have port fu_en  output  NUM_FU  per-slot start pulse to the FU EN input.
REQ-010 SHALL have port fu_finish  input  NUM_FU  per-slot one-cycle completion pulse from FU.
REQ-011 SHALL have port fu_res  input  NUM_FU*DATA_W  per-slot result; slot i occupies bits [i*DATA_W +: DATA_W].
REQ-012 SHALL have port flush  input  1  discard all in-flight operations.
REQ-013 SHALL have port wb_valid, wb_ready, wb_rd (5), wb_data (DATA_W), wb_fu (log2(NUM_FU)): writeback output handshake; wb_ready is the input.

Function
REQ-014 Each slot SHALL hold a state in {IDLE, WAIT, DONE, DRAIN}, a 5-bit rd, and a DATA_W result buffer.
REQ-015 issue_ready SHALL be high only when target slot is IDLE and no slot in WAIT/DONE holds the same rd with rd != 0; it SHALL be low while flush is high.
REQ-016 On issue handshake: slot rd <= issue_rd, slot IDLE -> WAIT, fu_en[slot] high for exactly the next cycle only.
REQ-017 fu_en bits SHALL never be high for more than one consecutive cycle and never for a slot not just issued.
REQ-018 fu_finish[i] in WAIT SHALL capture fu_res slice i into the buffer and move the slot to DONE, or to IDLE if rd == 0 (no writeback).
REQ-019 fu_finish[i] while slot i is IDLE or DONE SHALL be ignored; no state or buffer change.
REQ-020 wb_valid SHALL be high whenever any slot is DONE; wb_fu = lowest-index DONE slot; wb_rd/wb_data from that slot; outputs held stable until wb_ready.
REQ-021 On wb handshake the selected slot SHALL go DONE -> IDLE; a freed slot is issuable no earlier than the following cycle (no same-cycle bypass).
REQ-022 Latency: issue handshake at edge T -> fu_en at cycle T+1; finish at cycle F -> wb_valid at F+1 if no lower-index slot is DONE.
REQ-023 Simultaneous finishes on several slots SHALL all be captured the same edge; writebacks drain in ascending index, one per wb handshake.
REQ-024 flush SHALL move WAIT slots to DRAIN and DONE slots to IDLE, and suppress issue that cycle; fu_en pending for the same cycle SHALL still complete its pulse.
REQ-025 A DRAIN slot SHALL discard its next fu_finish and then go IDLE; DRAIN slots SHALL not be issuable and SHALL not raise wb_valid.
REQ-026 Flush and finish on a WAIT slot in the same cycle: result discarded, slot -> IDLE.

Reset
REQ-027 With rst high at an edge: all slots IDLE, rd and buffers 0, fu_en 0, wb_valid 0, wb_rd 0, wb_data 0, wb_fu 0; issue_ready 0 during the reset cycle.
REQ-028 rst mid-operation SHALL abandon all in-flight work without DRAIN; stale fu_finish after reset SHALL be ignored per REQ-019.
REQ-029 rst SHALL take priority over flush, issue, finish and writeback.

Verification
REQ-030 Issue fu=1 rd=5, finish[1] 8 cycles later with res 0x0000_0030, wb_ready=1 -> fu_en[1] one-cycle pulse at T+1; wb_valid next cycle with wb_rd=5, wb_data=0x30, wb_fu=1.
REQ-031 finish[0] and finish[2] same cycle (rd 3, rd 4), wb_ready=1 -> rd 3 written first, rd 4 next cycle; both slots IDLE afterwards.
REQ-032 Slot 0 busy with rd=7; issue slot 1 rd=7 -> issue_ready=0 until rd 7 writeback; issue slot 1 rd=0 while slot 0 busy -> accepted, finish produces no wb_valid.
REQ-033 Issue slot 2 rd=9, flush 3 cycles later, then finish[2] -> no wb_valid; slot 2 issue_ready=0 until finish arrives, then 1.
REQ-034 wb_ready=0 for 5 cycles with slot 3 DONE (data 0xDEAD_BEEF) -> wb_valid, wb_rd, wb_data stable for all 5 cycles; spurious finish[3] during DONE ignored.
REQ-035 rst asserted while slots 0 and 1 in WAIT -> all outputs at reset values next cycle; later finish[0] produces no wb_valid.

Source files
------------

// File: rtl/fu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fu_issue_ctrl
//  Description : Issue/writeback controller for NUM_FU functional-unit slots
//                driven by an EN start pulse and a finish completion pulse.
//                Tracks each slot as IDLE/WAIT/DONE/DRAIN, blocks issue on
//                destination-register hazards, buffers results and drains
//                them through a valid/ready writeback port.
//  Revision    : 1.0 - initial release
// ============================================================================
module fu_issue_ctrl #(
  parameter int NUM_FU = 4,
  parameter int DATA_W = 32,
  localparam int FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic [FU_W-1:0]          issue_fu,
  input  logic [4:0]               issue_rd,
  output logic                     issue_ready,
  output logic [NUM_FU-1:0]        fu_en,
  input  logic [NUM_FU-1:0]        fu_finish,
  input  logic [NUM_FU*DATA_W-1:0] fu_res,
  input  logic                     flush,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [4:0]               wb_rd,
  output logic [DATA_W-1:0]        wb_data,
  output logic [FU_W-1:0]          wb_fu
);

  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_WAIT  = 2'd1,
    SLOT_DONE  = 2'd2,
    SLOT_DRAIN = 2'd3
  } slot_state_e;

  slot_state_e          state_q [NUM_FU];
  logic [4:0]           rd_q    [NUM_FU];
  logic [DATA_W-1:0]    buf_q   [NUM_FU];
  logic [NUM_FU-1:0]    fu_en_q;
  // Remembers a writeback that was offered but not yet taken, so a lower
  // slot finishing meanwhile cannot swap the presented result under the sink.
  logic                 hold_q;
  logic [FU_W-1:0]      hold_idx_q;

  logic                 rd_conflict;
  logic                 done_any;
  logic [FU_W-1:0]      done_idx;
  logic [FU_W-1:0]      wb_sel;
  logic                 wb_any;
  logic                 issue_fire;
  logic                 wb_fire;

  // Hazard check: an in-flight (WAIT/DONE) slot already owns this destination.
  always_comb begin
    rd_conflict = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      if ((state_q[i] == SLOT_WAIT || state_q[i] == SLOT_DONE) &&
          rd_q[i] == issue_rd) begin
        rd_conflict = 1'b1;
      end
    end
  end

  // rd 0 never writes back, so it can never create a hazard.
  assign issue_ready = !rst && !flush &&
                       (state_q[issue_fu] == SLOT_IDLE) &&
                       !((issue_rd != 5'd0) && rd_conflict);
  assign issue_fire  = issue_valid && issue_ready;

  // Lowest-index DONE slot, scanned downward so the smallest index wins.
  always_comb begin
    done_any = 1'b0;
    done_idx = '0;
    for (int i = NUM_FU - 1; i >= 0; i--) begin
      if (state_q[i] == SLOT_DONE) begin
        done_any = 1'b1;
        done_idx = FU_W'(i);
      end
    end
  end

  // A held slot is always still DONE: only flush or reset can leave DONE
  // without a handshake, and both clear the hold.
  assign wb_sel   = hold_q ? hold_idx_q : done_idx;
  assign wb_any   = hold_q || done_any;
  assign wb_fire  = wb_any && wb_ready;

  assign wb_valid = wb_any;
  assign wb_fu    = wb_any ? wb_sel        : '0;
  assign wb_rd    = wb_any ? rd_q[wb_sel]  : 5'd0;
  assign wb_data  = wb_any ? buf_q[wb_sel] : '0;
  assign fu_en    = fu_en_q;

  // Slot state machines, start pulse and writeback hold register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_FU; i++) begin
        state_q[i] <= SLOT_IDLE;
        rd_q[i]    <= 5'd0;
        buf_q[i]   <= '0;
      end
      fu_en_q    <= '0;
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
    end else begin
      // One-cycle start pulse; the slot is WAIT next cycle so it cannot repeat.
      fu_en_q    <= issue_fire ? (NUM_FU'(1) << issue_fu) : '0;
      hold_q     <= !flush && wb_any && !wb_ready;
      hold_idx_q <= wb_sel;

      for (int i = 0; i < NUM_FU; i++) begin
        case (state_q[i])
          SLOT_IDLE: begin
            if (issue_fire && issue_fu == FU_W'(i)) begin
              state_q[i] <= SLOT_WAIT;
              rd_q[i]    <= issue_rd;
            end
          end
          SLOT_WAIT: begin
            if (flush) begin
              // A finish landing with the flush is simply dropped.
              state_q[i] <= fu_finish[i] ? SLOT_IDLE : SLOT_DRAIN;
            end else if (fu_finish[i]) begin
              buf_q[i]   <= fu_res[i*DATA_W +: DATA_W];
              state_q[i] <= (rd_q[i] == 5'd0) ? SLOT_IDLE : SLOT_DONE;
            end
          end
          SLOT_DONE: begin
            if (flush || (wb_fire && wb_sel == FU_W'(i))) begin
              state_q[i] <= SLOT_IDLE;
            end
          end
          SLOT_DRAIN: begin
            // The unit is still busy with the flushed op; wait out its finish.
            if (fu_finish[i]) begin
              state_q[i] <= SLOT_IDLE;
            end
          end
          default: state_q[i] <= SLOT_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fu_issue_ctrl
//  Description : Self-checking bench for fu_issue_ctrl: directed scenarios
//                followed by random traffic, all compared against a
//                slot-occupancy reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fu_issue_ctrl;

  localparam int NUM_FU = 4;
  localparam int DATA_W = 32;
  localparam int FU_W   = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     issue_valid;
  logic [FU_W-1:0]          issue_fu;
  logic [4:0]               issue_rd;
  logic                     issue_ready;
  logic [NUM_FU-1:0]        fu_en;
  logic [NUM_FU-1:0]        fu_finish;
  logic [NUM_FU*DATA_W-1:0] fu_res;
  logic                     flush;
  logic                     wb_valid;
  logic                     wb_ready;
  logic [4:0]               wb_rd;
  logic [DATA_W-1:0]        wb_data;
  logic [FU_W-1:0]          wb_fu;

  always #5 clk = ~clk;

  fu_issue_ctrl #(.NUM_FU(NUM_FU), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_fu    (issue_fu),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .fu_en       (fu_en),
    .fu_finish   (fu_finish),
    .fu_res      (fu_res),
    .flush       (flush),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .wb_fu       (wb_fu)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: what each slot is doing in plain terms.
  // 0 = free, 1 = unit running, 2 = result waiting for writeback, 3 = discarding
  int          occ      [NUM_FU];
  logic [4:0]  m_rd     [NUM_FU];
  logic [31:0] m_res    [NUM_FU];
  bit          offered;      // a writeback was shown last cycle and not taken
  int          offered_slot;
  logic [3:0]  m_start;      // start pulse expected this cycle

  function automatic void model_reset();
    for (int i = 0; i < NUM_FU; i++) begin
      occ[i] = 0; m_rd[i] = 5'd0; m_res[i] = 32'd0;
    end
    offered = 0; offered_slot = 0; m_start = 4'd0;
  endfunction

  function automatic logic [127:0] rnd_res();
    logic [127:0] r;
    for (int i = 0; i < NUM_FU; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [127:0] mkres(input int slot, input logic [31:0] val);
    logic [127:0] r;
    r = rnd_res();
    r[slot*32 +: 32] = val;
    return r;
  endfunction

  // One clock cycle: drive at negedge, check settled outputs, advance the model at posedge.
  task automatic cycle(input bit r, input bit v, input int fu, input int rd,
                       input logic [3:0] fin, input bit fl, input bit wr,
                       input logic [127:0] res);
    bit e_ready, e_wbv, acc, wbf;
    int e_sel;
    rst = r; issue_valid = v; issue_fu = fu[1:0]; issue_rd = rd[4:0];
    fu_finish = fin; flush = fl; wb_ready = wr; fu_res = res;
    #1;
    e_ready = !r && !fl && (occ[fu] == 0);
    for (int j = 0; j < NUM_FU; j++)
      if (rd != 0 && (occ[j] == 1 || occ[j] == 2) && m_rd[j] == rd[4:0]) e_ready = 0;
    e_wbv = 0; e_sel = 0;
    if (offered && occ[offered_slot] == 2) begin
      e_wbv = 1; e_sel = offered_slot;
    end else begin
      for (int j = 0; j < NUM_FU; j++)
        if (!e_wbv && occ[j] == 2) begin e_wbv = 1; e_sel = j; end
    end
    check("issue_ready", issue_ready, e_ready);
    check("fu_en", fu_en, m_start);
    check("wb_valid", wb_valid, e_wbv);
    if (e_wbv) begin
      check("wb_fu", wb_fu, e_sel);
      check("wb_rd", wb_rd, m_rd[e_sel]);
      check("wb_data", wb_data, m_res[e_sel]);
    end
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      acc = v && e_ready;
      wbf = e_wbv && wr;
      m_start = acc ? (4'd1 << fu) : 4'd0;
      for (int i = 0; i < NUM_FU; i++) begin
        if (fl) begin
          if (occ[i] == 1) occ[i] = fin[i] ? 0 : 3;
          else if (occ[i] == 2) occ[i] = 0;
          else if (occ[i] == 3 && fin[i]) occ[i] = 0;
        end else if (occ[i] == 0) begin
          if (acc && fu == i) begin occ[i] = 1; m_rd[i] = rd[4:0]; end
        end else if (occ[i] == 1) begin
          if (fin[i]) begin
            m_res[i] = res[i*32 +: 32];
            occ[i] = (m_rd[i] == 5'd0) ? 0 : 2;
          end
        end else if (occ[i] == 2) begin
          if (wbf && e_sel == i) occ[i] = 0;
        end else if (fin[i]) begin
          occ[i] = 0;
        end
      end
      offered = !fl && e_wbv && !wr;
      offered_slot = e_sel;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit wr);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 4'd0, 0, wr, rnd_res());
  endtask

  initial begin
    rst = 1'b1; issue_valid = 1'b0; issue_fu = '0; issue_rd = '0;
    fu_finish = '0; fu_res = '0; flush = 1'b0; wb_ready = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    // Reset values, rst still asserted
    check("rst_fu_en", fu_en, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_rd", wb_rd, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_wb_fu", wb_fu, 0);
    check("rst_issue_ready", issue_ready, 0);
    cycle(1, 0, 0, 0, 4'd0, 0, 0, rnd_res());

    // Basic issue / finish / writeback on slot 1
    cycle(0, 1, 1, 5, 4'd0, 0, 1, rnd_res());
    check("b_en_pulse", fu_en, 4'b0010);
    idle(7, 1);
    cycle(0, 0, 0, 0, 4'b0010, 0, 1, mkres(1, 32'h0000_0030));
    check("b_wb_valid", wb_valid, 1);
    check("b_wb_rd", wb_rd, 5);
    check("b_wb_data", wb_data, 32'h30);
    check("b_wb_fu", wb_fu, 1);
    idle(2, 1);

    // Simultaneous finishes drain in ascending order
    cycle(0, 1, 0, 3, 4'd0, 0, 1, rnd_res());
    cycle(0, 1, 2, 4, 4'd0, 0, 1, rnd_res());
    idle(2, 1);
    cycle(0, 0, 0, 0, 4'b0101, 0, 1, rnd_res());
    check("sim_first_rd", wb_rd, 3);
    cycle(0, 0, 0, 0, 4'd0, 0, 1, rnd_res());
    check("sim_second_rd", wb_rd, 4);
    cycle(0, 0, 0, 0, 4'd0, 0, 1, rnd_res());
    check("sim_drained", wb_valid, 0);

    // rd hazard blocks issue; rd 0 never blocks and never writes back
    cycle(0, 1, 0, 7, 4'd0, 0, 1, rnd_res());
    cycle(0, 1, 1, 7, 4'd0, 0, 1, rnd_res());
    cycle(0, 1, 1, 7, 4'd0, 0, 1, rnd_res());
    cycle(0, 1, 1, 0, 4'd0, 0, 1, rnd_res());
    idle(2, 1);
    cycle(0, 0, 0, 0, 4'b0010, 0, 1, rnd_res());
    check("rd0_no_wb", wb_valid, 0);
    cycle(0, 0, 0, 0, 4'b0001, 0, 1, rnd_res());
    cycle(0, 1, 1, 7, 4'd0, 0, 1, rnd_res());
    cycle(0, 1, 1, 7, 4'd0, 0, 1, rnd_res());
    idle(2, 1);
    cycle(0, 0, 0, 0, 4'b0010, 0, 1, rnd_res());
    idle(2, 1);

    // Flush turns a running slot into a discarding one
    cycle(0, 1, 2, 9, 4'd0, 0, 1, rnd_res());
    idle(2, 1);
    cycle(0, 0, 0, 0, 4'd0, 1, 1, rnd_res());
    cycle(0, 1, 2, 9, 4'd0, 0, 1, rnd_res());
    cycle(0, 1, 2, 9, 4'b0100, 0, 1, rnd_res());
    check("drain_no_wb", wb_valid, 0);
    cycle(0, 1, 2, 9, 4'd0, 0, 1, rnd_res());
    check("drain_reissue_en", fu_en, 4'b0100);
    cycle(0, 0, 0, 0, 4'b0100, 0, 1, rnd_res());
    idle(2, 1);

    // Back-pressure with a spurious finish while DONE
    cycle(0, 1, 3, 12, 4'd0, 0, 0, rnd_res());
    cycle(0, 0, 0, 0, 4'b1000, 0, 0, mkres(3, 32'hDEAD_BEEF));
    for (int k = 0; k < 5; k++)
      cycle(0, 0, 0, 0, (k == 2) ? 4'b1000 : 4'd0, 0, 0, mkres(3, 32'h1234_5678));
    check("bp_data_held", wb_data, 32'hDEAD_BEEF);
    check("bp_rd_held", wb_rd, 12);
    idle(2, 1);

    // Reset in mid-flight abandons work; stale finish ignored
    cycle(0, 1, 0, 1, 4'd0, 0, 1, rnd_res());
    cycle(0, 1, 1, 2, 4'd0, 0, 1, rnd_res());
    cycle(1, 0, 0, 0, 4'd0, 0, 1, rnd_res());
    check("mid_rst_wb_valid", wb_valid, 0);
    check("mid_rst_fu_en", fu_en, 0);
    check("mid_rst_wb_data", wb_data, 0);
    cycle(0, 0, 0, 0, 4'b0001, 0, 1, rnd_res());
    check("stale_fin_no_wb", wb_valid, 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] fin;
      for (int i = 0; i < NUM_FU; i++) fin[i] = ($urandom_range(4) == 0);
      cycle($urandom_range(99) == 0, $urandom_range(9) < 7,
            int'($urandom_range(NUM_FU - 1)), int'($urandom_range(7)),
            fin, $urandom_range(29) == 0, $urandom_range(9) < 6, rnd_res());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
